axil_reg_if_wr_resp: RTL and testbench
======================================

// Module: axil_reg_if_wr_resp
// PURPOSE
//  AXI-Lite write slave to single-cycle register-write port; successor of basic reg-if write bridge.
//  Adds address-window decode (DECERR), AWPROT access check (SLVERR), slave-signalled error,
//  configurable timeout with selectable response, timeout event pulse. Sits between AXI-Lite interconnect and CSR blocks.
// PARAMETERS
//  DATA_WIDTH    32             data bus width, bits (multiple of 8)
//  ADDR_WIDTH    32             address width, bits
//  STRB_WIDTH    DATA_WIDTH/8   byte strobe width
//  TIMEOUT       4              cycles without ack before forced completion; 0 = never time out
//  TIMEOUT_ERR   1              1: timeout completes with SLVERR; 0: with OKAY
//  BASE_ADDR     0              decode window base (aligned to 2**WINDOW_WIDTH)
//  WINDOW_WIDTH  ADDR_WIDTH     window size 2**WINDOW_WIDTH bytes; ADDR_WIDTH = accept all
//  SECURE_ONLY   0              1: writes with awprot[1]=1 (non-secure) rejected with SLVERR
// PORTS
//  clk             in   1           clock
//  rst             in   1           asynchronous reset, active-high
//  s_axil_awaddr   in   ADDR_WIDTH  write address
//  s_axil_awprot   in   3           protection bits
//  s_axil_awvalid  in   1           / s_axil_awready out 1: AW handshake
//  s_axil_wdata    in   DATA_WIDTH  write data
//  s_axil_wstrb    in   STRB_WIDTH  byte strobes
//  s_axil_wvalid   in   1           / s_axil_wready out 1: W handshake
//  s_axil_bresp    out  2           00 OKAY, 10 SLVERR, 11 DECERR
//  s_axil_bvalid   out  1           / s_axil_bready in 1: B handshake
//  reg_wr_addr     out  ADDR_WIDTH  captured address (full, not offset)
//  reg_wr_data     out  DATA_WIDTH  captured data
//  reg_wr_strb     out  STRB_WIDTH  captured strobes
//  reg_wr_en       out  1           write request, held until ack/timeout
//  reg_wr_wait     in   1           slave busy: freezes timeout count
//  reg_wr_ack      in   1           write complete
//  reg_wr_err      in   1           qualifies ack: SLVERR
//  timeout_evt     out  1           one-cycle pulse on timeout completion
// BEHAVIOUR
//  Reset (async): awready=wready=1, bvalid=0, bresp=00, reg_wr_en=0, timeout_evt=0; data/addr regs not reset.
//  Reset mid-op: transaction dropped, no B response issued, no further reg_wr_en.
//  AW and W captured independently into 1-deep holding regs; awready=!aw_held, wready=!w_held.
//  FSM: IDLE -> (aw_held & w_held & !bvalid) -> CHECK decision same edge:
//   addr[ADDR_WIDTH-1:WINDOW_WIDTH] != BASE_ADDR upper bits -> RESP, bresp=11, no reg_wr_en.
//   else SECURE_ONLY & awprot[1] -> RESP, bresp=10, no reg_wr_en. DECERR has priority over SLVERR.
//   else ACCESS: reg_wr_en=1 from next cycle; timeout count loaded TIMEOUT-1.
//  ACCESS: count decrements each cycle reg_wr_en=1 & !reg_wr_wait & count!=0.
//   reg_wr_ack -> RESP, bresp = reg_wr_err ? 10 : 00; reg_wr_en low next cycle.
//   count==0 & !ack & TIMEOUT!=0 -> RESP, bresp = TIMEOUT_ERR ? 10 : 00, timeout_evt=1 one cycle.
//   ack and timeout same cycle: ack wins, no timeout_evt. reg_wr_err ignored without ack.
//  Completion (either path) clears aw_held/w_held same edge bvalid rises: next AW/W may be
//   captured while bvalid pending; next reg_wr_en not issued until B handshake done.
//  RESP: bvalid, bresp stable until bready; bvalid&bready -> IDLE (new request may start next cycle).
//  Latency: AW+W accepted edge 0 -> reg_wr_en cycle 1; ack in cycle 1 -> bvalid cycle 2.
//  Decode error: accept edge 0 -> bvalid cycle 1. Exactly one reg_wr_en pulse-train per write.
//  reg_wr_addr/data/strb stable whenever reg_wr_en=1.
// TESTING
//  1 AW+W same cycle addr 0x10 data 0xDEADBEEF strb F, ack cycle 1 -> one reg_wr_en cycle, bresp 00, bvalid cycle 2.
//  2 W 3 cycles before AW; bready low 5 cycles -> no reg_wr_en until AW; bvalid/bresp held; second write's reg_wr_en waits for B handshake.
//  3 TIMEOUT=4, no ack, wait low -> reg_wr_en 4 cycles, timeout_evt pulse, bresp 10; TIMEOUT_ERR=0 -> bresp 00.
//  4 reg_wr_wait high 10 cycles then ack with reg_wr_err=1 -> no timeout, bresp 10; ack on count==0 -> no timeout_evt.
//  5 BASE_ADDR=0x1000 WINDOW_WIDTH=8: addr 0x2004 -> bresp 11, no reg_wr_en; SECURE_ONLY, awprot=010 -> bresp 10.
//  6 assert rst during ACCESS -> outputs at reset values immediately, no bvalid after release; next write completes normally.

Source files
------------

// File: rtl/axil_reg_if_wr_resp.sv
// AXI-Lite write slave driving a single-cycle register-write port, with window decode,
// protection check, slave error and a bounded wait on the register acknowledge.
module axil_reg_if_wr_resp #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int                    TIMEOUT      = 4,
  parameter int                    TIMEOUT_ERR  = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    WINDOW_WIDTH = ADDR_WIDTH,
  parameter int                    SECURE_ONLY  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [STRB_WIDTH-1:0] reg_wr_strb,
  output logic                  reg_wr_en,
  input  logic                  reg_wr_wait,
  input  logic                  reg_wr_ack,
  input  logic                  reg_wr_err,
  output logic                  timeout_evt
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [ADDR_WIDTH-1:0] UPPER_MASK =
    (WINDOW_WIDTH >= ADDR_WIDTH) ? '0 : ({ADDR_WIDTH{1'b1}} << WINDOW_WIDTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [1:0]            bresp_nxt;
  logic                  evt_nxt;
  logic                  complete;
  logic                  aw_held, w_held;
  logic [2:0]            aw_prot;
  logic                  decerr, prot_err;

  // Every channel transfers on the edge where valid and ready are both high; the
  // source holds its payload stable until then, and ready here never depends on valid.
  assign s_axil_awready = !aw_held;
  assign s_axil_wready  = !w_held;
  assign s_axil_bvalid  = (state == RESP);
  assign reg_wr_en      = (state == ACCESS);

  assign decerr   = ((reg_wr_addr ^ BASE_ADDR) & UPPER_MASK) != '0;
  assign prot_err = (SECURE_ONLY != 0) && aw_prot[1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bresp_nxt = s_axil_bresp;
    evt_nxt   = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (aw_held && w_held) begin
          if (decerr) begin
            state_nxt = RESP;
            bresp_nxt = 2'b11;
            complete  = 1'b1;
          end else if (prot_err) begin
            state_nxt = RESP;
            bresp_nxt = 2'b10;
            complete  = 1'b1;
          end else begin
            state_nxt = ACCESS;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      ACCESS: begin
        // An ack in the same cycle as expiry still counts as a normal completion.
        if (reg_wr_ack) begin
          state_nxt = RESP;
          bresp_nxt = reg_wr_err ? 2'b10 : 2'b00;
          complete  = 1'b1;
        end else if (TO_EN && cnt == '0) begin
          state_nxt = RESP;
          bresp_nxt = (TIMEOUT_ERR != 0) ? 2'b10 : 2'b00;
          evt_nxt   = 1'b1;
          complete  = 1'b1;
        end else if (!reg_wr_wait && cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (s_axil_bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      s_axil_bresp <= 2'b00;
      timeout_evt  <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      s_axil_bresp <= bresp_nxt;
      timeout_evt  <= evt_nxt;
    end
  end

  // Holding flags drop as the response is raised, so the next AW/W can queue behind B.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (complete) aw_held <= 1'b0;
      else if (s_axil_awvalid && !aw_held) aw_held <= 1'b1;
      if (complete) w_held <= 1'b0;
      else if (s_axil_wvalid && !w_held) w_held <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (s_axil_awvalid && !aw_held) begin
      reg_wr_addr <= s_axil_awaddr;
      aw_prot     <= s_axil_awprot;
    end
    if (s_axil_wvalid && !w_held) begin
      reg_wr_data <= s_axil_wdata;
      reg_wr_strb <= s_axil_wstrb;
    end
  end

endmodule

// File: tb/tb_axil_reg_if_wr_resp.sv
// Directed bench: instance a uses defaults (full window, SLVERR timeout); instance b uses a
// 256-byte window at 0x1000, secure-only access and OKAY on timeout. Both share stimulus.
module tb_axil_reg_if_wr_resp;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          awvalid, wvalid, bready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wr_wait, wr_ack, wr_err;

  logic          a_awready, a_wready, a_bvalid, a_en, a_evt;
  logic [1:0]    a_bresp;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic [SW-1:0] a_strb;
  logic          b_awready, b_wready, b_bvalid, b_en, b_evt;
  logic [1:0]    b_bresp;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic [SW-1:0] b_strb;

  axil_reg_if_wr_resp dut_a (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid),
    .s_axil_awready(a_awready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
    .s_axil_wvalid(wvalid), .s_axil_wready(a_wready), .s_axil_bresp(a_bresp),
    .s_axil_bvalid(a_bvalid), .s_axil_bready(bready), .reg_wr_addr(a_addr),
    .reg_wr_data(a_data), .reg_wr_strb(a_strb), .reg_wr_en(a_en),
    .reg_wr_wait(wr_wait), .reg_wr_ack(wr_ack), .reg_wr_err(wr_err), .timeout_evt(a_evt)
  );

  axil_reg_if_wr_resp #(
    .TIMEOUT_ERR(0), .BASE_ADDR(32'h0000_1000), .WINDOW_WIDTH(8), .SECURE_ONLY(1)
  ) dut_b (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid),
    .s_axil_awready(b_awready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
    .s_axil_wvalid(wvalid), .s_axil_wready(b_wready), .s_axil_bresp(b_bresp),
    .s_axil_bvalid(b_bvalid), .s_axil_bready(bready), .reg_wr_addr(b_addr),
    .reg_wr_data(b_data), .reg_wr_strb(b_strb), .reg_wr_en(b_en),
    .reg_wr_wait(wr_wait), .reg_wr_ack(wr_ack), .reg_wr_err(wr_err), .timeout_evt(b_evt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: one {addr,data} entry per write expected to reach the register port of dut_a.
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic        prev_en = 1'b0;
  logic [31:0] hold_addr = '0;

  always @(negedge clk) begin
    if (a_en && !prev_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr_en", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", a_addr, mon_e[63:32]);
        check("wr_data", a_data, mon_e[31:0]);
        hold_addr = mon_e[63:32];
      end
    end else if (a_en) begin
      check("wr_addr_stable", a_addr, hold_addr);
    end
    prev_en = a_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] addr, input logic [2:0] prot,
                      input logic [31:0] data, input logic [3:0] strb);
    awaddr  = addr;
    awprot  = prot;
    wdata   = data;
    wstrb   = strb;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    exp_q.push_back({addr, data});
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  task automatic handshake();
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
    logic [1:0]  exp_b;
  } dec_vec_t;

  dec_vec_t dec_tab [4];
  int n;

  initial begin
    awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 0; wr_wait = 0; wr_ack = 0; wr_err = 0;
    rst = 1'b1;
    #2;
    check("rst_awready", a_awready, 1);
    check("rst_wready", a_wready, 1);
    check("rst_bvalid", a_bvalid, 0);
    check("rst_bresp", a_bresp, 0);
    check("rst_en", a_en, 0);
    check("rst_evt", a_evt, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Basic write, ack in cycle 1; b decodes 0x10 outside its window.
    send(32'h10, 3'b000, 32'hDEAD_BEEF, 4'hF);
    check("t1_awready_held", a_awready, 0);
    check("t1_en_c0", a_en, 0);
    tick();
    check("t1_en_c1", a_en, 1);
    check("t1_strb", a_strb, 4'hF);
    check("t1_b_decerr_c1", b_bvalid, 1);
    check("t1_b_en", b_en, 0);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    check("t1_bvalid_c2", a_bvalid, 1);
    check("t1_bresp", a_bresp, 2'b00);
    check("t1_en_c2", a_en, 0);
    check("t1_b_bresp", b_bresp, 2'b11);
    handshake();
    check("t1_bvalid_done", a_bvalid, 0);
    check("t1_awready_free", a_awready, 1);

    // W leads AW by three cycles; second write queues behind a stalled B.
    wdata = 32'h1111_1111; wstrb = 4'h3; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_wready_held", a_wready, 0);
      check("t2_awready", a_awready, 1);
      check("t2_no_en", a_en, 0);
      tick();
    end
    awaddr = 32'h1020; awprot = 3'b000; awvalid = 1'b1;
    exp_q.push_back({32'h1020, 32'h1111_1111});
    tick();
    awvalid = 1'b0;
    tick();
    check("t2_en", a_en, 1);
    check("t2_strb", a_strb, 4'h3);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    check("t2_bvalid", a_bvalid, 1);
    awaddr = 32'h1024; wdata = 32'h2222_2222; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    exp_q.push_back({32'h1024, 32'h2222_2222});
    for (int i = 0; i < 5; i++) begin
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      check("t2_bvalid_hold", a_bvalid, 1);
      check("t2_bresp_hold", a_bresp, 2'b00);
      check("t2_en_blocked", a_en, 0);
      check("t2_aw_queued", a_awready, 0);
    end
    handshake();
    check("t2_b_done", a_bvalid, 0);
    check("t2_en_idle", a_en, 0);
    tick();
    check("t2_en_second", a_en, 1);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    check("t2_bvalid_second", a_bvalid, 1);
    handshake();

    // Timeout: four request cycles, then a one-cycle event with the first bvalid cycle.
    send(32'h1030, 3'b000, 32'h3333_3333, 4'hF);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (a_bvalid) break;
      if (a_en) n++;
    end
    check("t3_bvalid", a_bvalid, 1);
    check("t3_en_cycles", n, 4);
    check("t3_evt", a_evt, 1);
    check("t3_bresp_slverr", a_bresp, 2'b10);
    check("t3_b_bresp_okay", b_bresp, 2'b00);
    check("t3_b_evt", b_evt, 1);
    handshake();
    check("t3_evt_clear", a_evt, 0);
    check("t3_bvalid_done", a_bvalid, 0);

    // Wait freezes the count for ten cycles; err without ack is ignored.
    wr_wait = 1'b1; wr_err = 1'b1;
    send(32'h1040, 3'b000, 32'h4444_4444, 4'hF);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_wait_en", a_en, 1);
      check("t4_wait_no_b", a_bvalid, 0);
    end
    wr_wait = 1'b0; wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0; wr_err = 1'b0;
    check("t4_bvalid", a_bvalid, 1);
    check("t4_bresp_err", a_bresp, 2'b10);
    check("t4_no_evt", a_evt, 0);
    handshake();

    // Ack arriving exactly when the count reaches zero.
    send(32'h1044, 3'b000, 32'h5555_5555, 4'hF);
    repeat (4) tick();
    check("t4b_en_c4", a_en, 1);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    check("t4b_bvalid", a_bvalid, 1);
    check("t4b_bresp", a_bresp, 2'b00);
    check("t4b_no_evt", a_evt, 0);
    handshake();

    // Window / protection decode on dut_b; dut_a accepts everything.
    dec_tab[0] = '{addr: 32'h2004, prot: 3'b000, exp_b: 2'b11};
    dec_tab[1] = '{addr: 32'h1008, prot: 3'b010, exp_b: 2'b10};
    dec_tab[2] = '{addr: 32'h2008, prot: 3'b010, exp_b: 2'b11};
    dec_tab[3] = '{addr: 32'h10FC, prot: 3'b001, exp_b: 2'b00};
    for (int i = 0; i < 4; i++) begin
      send(dec_tab[i].addr, dec_tab[i].prot, 32'h6000_0000 + i, 4'hF);
      tick();
      check("t5_b_bvalid_c1", b_bvalid, (dec_tab[i].exp_b != 2'b00) ? 1 : 0);
      check("t5_b_en_c1", b_en, (dec_tab[i].exp_b == 2'b00) ? 1 : 0);
      wr_ack = 1'b1;
      tick();
      wr_ack = 1'b0;
      check("t5_b_bvalid_c2", b_bvalid, 1);
      check("t5_b_bresp", b_bresp, dec_tab[i].exp_b);
      check("t5_a_bresp", a_bresp, 2'b00);
      check("t5_a_bvalid", a_bvalid, 1);
      handshake();
    end

    // Reset in the middle of an access drops the transaction.
    send(32'h1050, 3'b000, 32'h7777_7777, 4'hF);
    tick();
    check("t6_en_before", a_en, 1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_rst_en", a_en, 0);
    check("t6_rst_bvalid", a_bvalid, 0);
    check("t6_rst_awready", a_awready, 1);
    check("t6_rst_wready", a_wready, 1);
    check("t6_rst_evt", a_evt, 0);
    tick(); tick();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (a_bvalid || a_en || b_bvalid || b_en) n++;
    end
    check("t6_quiet_after_rst", n, 0);
    send(32'h1060, 3'b000, 32'h8888_8888, 4'hF);
    tick();
    check("t6_next_en", a_en, 1);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    check("t6_next_bvalid", a_bvalid, 1);
    check("t6_next_bresp", a_bresp, 2'b00);
    handshake();
    tick();

    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
